// File: rtl/attn_pkg.sv
// Shared FSM state type and constant helpers for the attention softmax stage.
package attn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAX   = 3'd1,
    ST_EXP   = 3'd2,
    ST_RECIP = 3'd3,
    ST_NORM  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // round(log2(e) * 2^frac_bits), evaluated in fixed point to stay elaboration-safe
  function automatic int log2e_q(input int frac_bits);
    longint scaled;
    scaled = (64'sd1442695 << frac_bits) + 64'sd500000;
    return int'(scaled / 64'sd1000000);
  endfunction

  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/softmax_exp2_approx.sv
// Combinational 2^(d*log2e) approximation: integer part becomes a right shift,
// fractional part is used linearly as the mantissa (1+f).
module softmax_exp2_approx
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic signed [DATA_WIDTH:0]   d,
  output logic        [DATA_WIDTH-1:0] e
);

  localparam int PW = DATA_WIDTH + FRAC_BITS + 3;
  localparam logic signed [PW-1:0] LOG2E = PW'(log2e_q(FRAC_BITS));

  logic signed [PW-1:0]   d_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   p;
  logic signed [PW-1:0]   k;
  logic signed [PW-1:0]   neg_k;
  logic [FRAC_BITS-1:0]   f;
  logic [DATA_WIDTH-1:0]  mant;

  always_comb begin
    d_ext = {{(PW-DATA_WIDTH-1){d[DATA_WIDTH]}}, d};
    prod  = d_ext * LOG2E;
    p     = prod >>> FRAC_BITS;
    k     = p >>> FRAC_BITS;
    f     = p[FRAC_BITS-1:0];
    neg_k = -k;
    mant  = DATA_WIDTH'({1'b1, f});
    e     = (neg_k >= PW'(DATA_WIDTH)) ? '0 : (mant >> neg_k);
  end

endmodule

// File: rtl/attn_softmax_stream.sv
// Row-serial fixed-point softmax between the QK^T and SV stages, V passed alongside.
// Optional build macro CAUSAL_MASK_EN masks elements above the diagonal (c > r).
module attn_softmax_stream
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0]   A_in,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]   V_in,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0]   S_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0]   V_out,
  output logic                                        busy
);

  localparam int DW = DATA_WIDTH;
  localparam int F  = FRAC_BITS;
  localparam int N  = TOKEN_NUM;
  localparam int NN = N * N;
  localparam int VW = DW * TOKEN_DIM * N;
  localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int IW = (clog2(NN) > 0) ? clog2(NN) : 1;
  localparam int SW = DW + clog2(N);
  localparam int RW = clog2(F + 1);
  localparam int QW = F + 1;
  localparam int PW = DW + QW;
  localparam logic [PW-1:0] ONE_P = PW'(1) << F;
  localparam logic [DW-1:0] ONE_D = DW'(1) << F;

  state_t state_reg, state_next;
  logic   accept, load_out;
  logic   col_last, row_last, recip_last;
  logic   masked;

  logic [CW-1:0] row_reg, col_reg;
  logic [RW-1:0] rcnt_reg;
  logic [IW-1:0] idx;

  logic signed [DW-1:0] a_in_arr [NN];
  logic signed [DW-1:0] a_mem    [NN];
  logic        [DW-1:0] s_mem    [NN];
  logic        [DW-1:0] e_mem    [N];
  logic        [VW-1:0] v_reg;
  logic   [NN*DW-1:0]   s_pack;

  logic signed [DW-1:0] x, m_reg;
  logic signed [DW:0]   d;
  logic [DW-1:0]        e_approx, e_val, s_val;
  logic [SW-1:0]        sum_reg, sum_next;
  logic [SW-1:0]        rem_reg;
  logic [SW:0]          rem_shift;
  logic [QW-1:0]        quo_reg;
  logic [PW-1:0]        norm_prod, norm_shift;

  for (genvar gi = 0; gi < NN; gi++) begin : g_elem
    assign a_in_arr[gi]          = A_in[gi*DW +: DW];
    assign s_pack[gi*DW +: DW]   = s_mem[gi];
  end

  assign idx        = IW'(elem_idx(int'(row_reg), int'(col_reg), N));
  assign x          = a_mem[idx];
  assign col_last   = (col_reg == CW'(N - 1));
  assign row_last   = (row_reg == CW'(N - 1));
  assign recip_last = (rcnt_reg == RW'(F));

`ifdef CAUSAL_MASK_EN
  assign masked = (col_reg > row_reg);
`else
  assign masked = 1'b0;
`endif

  // Difference is taken one bit wider so x - m can never wrap positive.
  assign d = {x[DW-1], x} - {m_reg[DW-1], m_reg};

  softmax_exp2_approx #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (F)
  ) u_exp2 (
    .d (d),
    .e (e_approx)
  );

  assign e_val      = masked ? '0 : e_approx;
  assign sum_next   = ((col_reg == '0) ? '0 : sum_reg) + SW'(e_val);
  assign rem_shift  = {rem_reg, 1'b0};
  assign norm_prod  = PW'(e_mem[col_reg]) * PW'(quo_reg);
  assign norm_shift = norm_prod >> F;
  assign s_val      = (norm_shift > ONE_P) ? ONE_D : DW'(norm_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // The last row always passes through WAIT for one cycle so the final
  // S write has landed before the output registers copy the buffer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid)   state_next = ST_MAX;
      ST_MAX:   if (col_last)   state_next = ST_EXP;
      ST_EXP:   if (col_last)   state_next = ST_RECIP;
      ST_RECIP: if (recip_last) state_next = ST_NORM;
      ST_NORM:  if (col_last)   state_next = row_last ? ST_WAIT : ST_MAX;
      ST_WAIT:  if (!out_valid || out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == ST_IDLE);
    busy     = (state_reg != ST_IDLE);
    accept   = in_valid && (state_reg == ST_IDLE);
    load_out = (state_reg == ST_WAIT) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg  <= '0;
      col_reg  <= '0;
      rcnt_reg <= '0;
      m_reg    <= '0;
      sum_reg  <= '0;
      rem_reg  <= '0;
      quo_reg  <= '0;
      v_reg    <= '0;
      for (int i = 0; i < NN; i++) begin
        a_mem[i] <= '0;
        s_mem[i] <= '0;
      end
      for (int i = 0; i < N; i++) e_mem[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            a_mem   <= a_in_arr;
            v_reg   <= V_in;
            row_reg <= '0;
            col_reg <= '0;
          end
        end
        ST_MAX: begin
          // Strict compare keeps the first occurrence on ties.
          if ((col_reg == '0) || (!masked && (x > m_reg))) m_reg <= x;
          col_reg <= col_last ? '0 : col_reg + CW'(1);
        end
        ST_EXP: begin
          e_mem[col_reg] <= e_val;
          sum_reg        <= sum_next;
          col_reg        <= col_last ? '0 : col_reg + CW'(1);
          if (col_last) begin
            // Top dividend bits of 2^(2F) preloaded; remaining bits are zero.
            rem_reg  <= SW'(1) << (F - 1);
            quo_reg  <= '0;
            rcnt_reg <= '0;
          end
        end
        ST_RECIP: begin
          if (rem_shift >= {1'b0, sum_reg}) begin
            rem_reg <= SW'(rem_shift - {1'b0, sum_reg});
            quo_reg <= {quo_reg[QW-2:0], 1'b1};
          end else begin
            rem_reg <= SW'(rem_shift);
            quo_reg <= {quo_reg[QW-2:0], 1'b0};
          end
          rcnt_reg <= rcnt_reg + RW'(1);
        end
        ST_NORM: begin
          s_mem[idx] <= s_val;
          col_reg    <= col_last ? '0 : col_reg + CW'(1);
          if (col_last) row_reg <= row_last ? '0 : row_reg + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // A fresh load wins over the drain of the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S_out     <= '0;
      V_out     <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      S_out     <= s_pack;
      V_out     <= v_reg;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_attn_softmax_stream.sv
// Scoreboard bench for attn_softmax_stream (N=4, D=4, 16-bit Q8.8, causal mask off).
module tb_attn_softmax_stream;

  localparam int DW = 16;
  localparam int F  = 8;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int AW = DW * N * N;
  localparam int VW = DW * D * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] A_in;
  logic [VW-1:0] V_in;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] S_out;
  logic [VW-1:0] V_out;
  logic          busy;

  typedef struct packed {
    logic [AW-1:0] s;
    logic [VW-1:0] v;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_t;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;

  attn_softmax_stream #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (F),
    .TOKEN_DIM  (D),
    .TOKEN_NUM  (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (A_in),
    .V_in      (V_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S_out     (S_out),
    .V_out     (V_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [4*DW-1:0] row4(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                           input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [AW-1:0] mat4(input logic [4*DW-1:0] r0, input logic [4*DW-1:0] r1,
                                         input logic [4*DW-1:0] r2, input logic [4*DW-1:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [VW-1:0] vseq(input int base);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < D * N; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  // Caller is positioned 1 time unit after a rising edge; returns likewise, after the accept edge.
  task automatic send(input logic [AW-1:0] a, input logic [VW-1:0] v,
                      input logic [AW-1:0] s_exp, input bit scored);
    int guard;
    guard = 0;
    while (!in_ready && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check("send_in_ready", in_ready, 1'b1);
    A_in     = a;
    V_in     = v;
    in_valid = 1'b1;
    if (scored) exp_q.push_back({s_exp, v});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_latency(input int lat_req, input string name);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, lat_req);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got S=%0h, required no output", S_out);
      end else begin
        mon_t = exp_q.pop_front();
        check("S_out", S_out, mon_t.s);
        check("V_out", V_out, mon_t.v);
        $display("[TB] txn %0d out S=%0h V=%0h", n_out, S_out, V_out);
        n_out++;
      end
    end
  end

  logic [DW-1:0] z, ng, nb, p1, s64, s256, s118, s45, s128;
  logic [AW-1:0] a_zero, s_all64, a2, s2, a3b, s3b;
  int            seen;

  initial begin
    z    = 16'h0000;  ng = 16'h8000;  nb = 16'hFF00;  p1 = 16'h0100;
    s64  = 16'h0040;  s256 = 16'h0100; s118 = 16'h0076; s45 = 16'h002D; s128 = 16'h0080;

    a_zero  = '0;
    s_all64 = mat4(row4(s64, s64, s64, s64), row4(s64, s64, s64, s64),
                   row4(s64, s64, s64, s64), row4(s64, s64, s64, s64));
    // -32768 knocks out, -1.0 gives e=99/sum=553, ties at max, max in last column
    a2 = mat4(row4(z, ng, ng, ng), row4(z, nb, nb, nb), row4(ng, z, ng, z), row4(nb, nb, nb, z));
    s2 = mat4(row4(s256, z, z, z), row4(s118, s45, s45, s45),
              row4(z, s128, z, s128), row4(s45, s45, s45, s118));
    a3b = mat4(row4(p1, z, z, z), row4(z, ng, ng, ng), row4(nb, nb, nb, nb), row4(z, nb, nb, nb));
    s3b = mat4(row4(s118, s45, s45, s45), row4(s256, z, z, z),
               row4(s64, s64, s64, s64), row4(s118, s45, s45, s45));

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A_in = '0; V_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_S_out", S_out, '0);
    check("rst_V_out", V_out, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);

    // uniform rows, first-output latency
    send(a_zero, vseq(1), s_all64, 1'b1);
    expect_latency(85, "t1_latency");
    repeat (2) @(posedge clk);
    #1;

    send(a2, vseq(100), s2, 1'b1);
    expect_latency(85, "t2_latency");
    repeat (2) @(posedge clk);
    #1;

    // downstream stall across a second transaction
    out_ready = 1'b0;
    send(a_zero, vseq(200), s_all64, 1'b1);
    expect_latency(85, "t3a_latency");
    send(a3b, vseq(300), s3b, 1'b1);
    repeat (85) @(posedge clk);
    #1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check("stall_S_stable", S_out, s_all64);
    end
    check("stall_in_wait", {busy, in_ready, out_valid}, 3'b101);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_S_next", S_out, s3b);
    check("release_valid_held", out_valid, 1'b1);
    check("release_idle", in_ready, 1'b1);
    @(posedge clk); #1;
    check("drain_valid_drop", out_valid, 1'b0);

    // reset during EXP of row 0 aborts the transaction
    send(a2, vseq(400), s2, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_exp_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_S_cleared", S_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 0);

    send(a_zero, vseq(500), s_all64, 1'b1);
    expect_latency(85, "t5_latency");
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
